// File: rtl/hazard_scoreboard.sv
// Data-hazard scoreboard: tracks destinations of the three in-flight stages and stalls issue on a match.
// Define HAZARD_FORWARD_EN for the forwarding policy (load-use only); otherwise full interlock.
module hazard_scoreboard #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [31:0]      instructionDEC,
    input  logic             issue_valid,
    input  logic             flush,
    output logic             pcenable,
    output logic             idifenable,
    output logic             idexNOP,
    output logic [CNT_W-1:0] stall_count
);

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_SLTI  = 6'b001010;
    localparam logic [5:0] OP_ANDI  = 6'b001100;
    localparam logic [5:0] OP_ORI   = 6'b001101;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_BNE   = 6'b000101;

    typedef struct packed {
        logic       valid;
        logic [4:0] dest;
        logic       is_load;
    } entry_t;

    entry_t           ex_r;
    entry_t           mem_r;
    entry_t           wb_r;
    entry_t           ex_next_s;
    logic [CNT_W-1:0] stall_count_r;

    logic [5:0] opcode_s;
    logic [4:0] rs_s;
    logic [4:0] rt_s;
    logic [4:0] dest_s;
    logic       has_dest_s;
    logic       use_rs_s;
    logic       use_rt_s;
    logic       is_load_s;
    logic       ex_elig_s;
    logic       mem_elig_s;
    logic       wb_elig_s;
    logic       hazard_s;
    logic       stall_s;
    logic       unused_s;

    // An eligible, valid entry whose destination equals the given source register.
    function automatic logic entry_hit(input entry_t e, input logic [4:0] src, input logic elig);
        return elig & e.valid & (e.dest == src);
    endfunction

    // A source of register zero never creates a dependency.
    function automatic logic src_hit(input logic use_src, input logic [4:0] src,
                                     input entry_t ex_e, input entry_t mem_e, input entry_t wb_e,
                                     input logic ex_el, input logic mem_el, input logic wb_el);
        return use_src & (src != 5'd0) &
               (entry_hit(ex_e, src, ex_el) | entry_hit(mem_e, src, mem_el) | entry_hit(wb_e, src, wb_el));
    endfunction

    assign opcode_s = instructionDEC[31:26];
    assign rs_s     = instructionDEC[25:21];
    assign rt_s     = instructionDEC[20:16];

    // Decode destination and source usage of the instruction waiting in IF/ID.
    always_comb begin
        dest_s     = 5'd0;
        has_dest_s = 1'b0;
        use_rs_s   = 1'b0;
        use_rt_s   = 1'b0;
        is_load_s  = 1'b0;
        case (opcode_s)
            OP_RTYPE: begin
                dest_s     = instructionDEC[15:11];
                has_dest_s = 1'b1;
                use_rs_s   = 1'b1;
                use_rt_s   = 1'b1;
            end
            OP_ADDI, OP_ORI, OP_ANDI, OP_SLTI: begin
                dest_s     = rt_s;
                has_dest_s = 1'b1;
                use_rs_s   = 1'b1;
            end
            OP_LW: begin
                dest_s     = rt_s;
                has_dest_s = 1'b1;
                use_rs_s   = 1'b1;
                is_load_s  = 1'b1;
            end
            OP_SW, OP_BEQ, OP_BNE: begin
                use_rs_s = 1'b1;
                use_rt_s = 1'b1;
            end
            default: begin
                dest_s     = 5'd0;
                has_dest_s = 1'b0;
            end
        endcase
    end

`ifdef HAZARD_FORWARD_EN
    // With forwarding only a load still in EX cannot supply its result in time.
    assign ex_elig_s  = ex_r.is_load;
    assign mem_elig_s = 1'b0;
    assign wb_elig_s  = 1'b0;
`else
    assign ex_elig_s  = 1'b1;
    assign mem_elig_s = 1'b1;
    assign wb_elig_s  = 1'b1;
`endif

    assign hazard_s = src_hit(use_rs_s, rs_s, ex_r, mem_r, wb_r, ex_elig_s, mem_elig_s, wb_elig_s) |
                      src_hit(use_rt_s, rt_s, ex_r, mem_r, wb_r, ex_elig_s, mem_elig_s, wb_elig_s);

    // Reset gating keeps the stall released even before the cleared entries propagate.
    assign stall_s = reset_n & issue_valid & ~flush & hazard_s;

    assign pcenable   = ~stall_s;
    assign idifenable = ~stall_s;
    assign idexNOP    = stall_s;
    assign stall_count = stall_count_r;

    // Build the entry entering EX; bubbles, kills, stalls and writes to $0 are recorded invalid.
    always_comb begin
        ex_next_s = '0;
        if (issue_valid && !flush && !stall_s && has_dest_s && (dest_s != 5'd0)) begin
            ex_next_s.valid   = 1'b1;
            ex_next_s.dest    = dest_s;
            ex_next_s.is_load = is_load_s;
        end else begin
            ex_next_s = '0;
        end
    end

    // Shadow pipeline shift EX -> MEM -> WB.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            ex_r  <= '0;
            mem_r <= '0;
            wb_r  <= '0;
        end else begin
            ex_r  <= ex_next_s;
            mem_r <= ex_r;
            wb_r  <= mem_r;
        end
    end

    // Saturating stall-cycle counter.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            stall_count_r <= '0;
        end else if (stall_s && (stall_count_r != {CNT_W{1'b1}})) begin
            stall_count_r <= stall_count_r + {{(CNT_W-1){1'b0}}, 1'b1};
        end
    end

    assign unused_s = ^{instructionDEC[10:0], mem_r.is_load, wb_r};

endmodule
